// File: rtl/pixel_unpacker_if.sv
// ---------------------------------------------------------------------------
// pixel_unpacker_if
// Byte-packed pixel stream (AXI4-Stream style) feeding the pixel unpacker.
//   tdata  : four packed pixel bytes, byte i = tdata[8i+7:8i]
//   tkeep  : carried for completeness, not used by the unpacker
//   tvalid : source has a word
//   tready : sink accepts the word this cycle
//   tlast  : word is the last of a line
//   tuser  : word is the first of a frame
// master drives the stream, slave consumes it.
// ---------------------------------------------------------------------------
interface pixel_unpacker_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast,
                    output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                    input tuser, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// ---------------------------------------------------------------------------
// pixel_unpacker
// Converts a stream of 32-bit words carrying packed 24-bit BGR pixels
// (4 pixels in every 3 words) into one pixel per handshake with x/y
// coordinates, start-of-frame / end-of-line markers and sticky framing
// error flags.
//
// Parameters
//   X_SIZE : pixels per line (multiple of 4)
//   Y_SIZE : lines per frame
// Ports
//   aclk, reset     : sole clock, asynchronous active-high reset
//   in_stream       : packed word stream (slave side)
//   r, g, b         : registered pixel colour
//   x, y            : column / row of the presented pixel
//   sof, eol        : pixel is (0,0) / pixel is the last of its line
//   pix_valid       : output pixel present, pix_ready : downstream accepts
//   sof_err         : sticky, tuser seen on a word that does not open a frame
//   eol_err         : sticky, tlast misplaced or missing
//   err_clear       : clears both sticky flags (a new error wins)
// Build option
//   PIXEL_UNPACKER_ERR_CNT_EN : adds saturating 16-bit error event counters
//                               sof_err_cnt / eol_err_cnt.
// ---------------------------------------------------------------------------
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic              aclk,
    input  logic              reset,
    pixel_unpacker_if.slave   in_stream,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic              sof,
    output logic              eol,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              sof_err,
    output logic              eol_err,
    input  logic              err_clear
`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    ,
    output logic [15:0]       sof_err_cnt,
    output logic [15:0]       eol_err_cnt
`endif
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    // Pixel 2 of the final group of a line is produced by the line's last word.
    localparam logic [9:0] X_PRE  = 10'(X_SIZE - 2);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    logic [1:0]  phase_r;
    logic [23:0] hold_r;
    logic [9:0]  xc_r;
    logic [8:0]  yc_r;
    logic        run_r;
    logic [7:0]  r_r, g_r, b_r;
    logic [9:0]  x_r;
    logic [8:0]  y_r;
    logic        sof_r, eol_r, pix_valid_r;
    logic        sof_err_r, eol_err_r;

    logic        out_free_s, in_ready_s, accept_s, flush_s, step_s;
    logic        first_word_s, last_word_s, sof_evt_s, eol_evt_s, eol_resync_s;
    logic [1:0]  ph_eff_s, phase_nx_s;
    logic [9:0]  xe_s, xc_nx_s;
    logic [8:0]  ye_s, yc_nx_s, y_adv_s;
    logic [23:0] hold_nx_s;
    logic [7:0]  pr_s, pg_s, pb_s;
    logic [31:0] d_s;
    logic        unused_s;

    assign unused_s = ^in_stream.tkeep;

    // Handshake, framing checks, byte decode and next-state selection.
    always_comb begin
        d_s          = in_stream.tdata;
        out_free_s   = !pix_valid_r || pix_ready;
        // No word is taken in P3: that cycle drains the three held bytes.
        in_ready_s   = run_r && (phase_r != P3) && out_free_s;
        accept_s     = in_stream.tvalid && in_ready_s;
        flush_s      = run_r && (phase_r == P3) && out_free_s;
        step_s       = accept_s || flush_s;
        first_word_s = (phase_r == P0) && (xc_r == 10'd0) && (yc_r == 9'd0);
        sof_evt_s    = accept_s && in_stream.tuser && !first_word_s;

        // A misplaced tuser restarts the frame with this word as word0.
        if (sof_evt_s) begin
            ph_eff_s = P0;
            xe_s     = 10'd0;
            ye_s     = 9'd0;
        end else begin
            ph_eff_s = phase_r;
            xe_s     = xc_r;
            ye_s     = yc_r;
        end

        last_word_s  = (ph_eff_s == P2) && (xe_s == X_PRE);
        eol_evt_s    = accept_s && (in_stream.tlast != last_word_s);
        eol_resync_s = accept_s && in_stream.tlast && !last_word_s;

        if (ye_s == Y_LAST) begin
            y_adv_s = 9'd0;
        end else begin
            y_adv_s = ye_s + 9'd1;
        end

        case (ph_eff_s)
            P0: begin
                pb_s       = d_s[7:0];
                pg_s       = d_s[15:8];
                pr_s       = d_s[23:16];
                hold_nx_s  = {16'h0000, d_s[31:24]};
                phase_nx_s = P1;
            end
            P1: begin
                pb_s       = hold_r[7:0];
                pg_s       = d_s[7:0];
                pr_s       = d_s[15:8];
                hold_nx_s  = {8'h00, d_s[31:16]};
                phase_nx_s = P2;
            end
            P2: begin
                pb_s       = hold_r[7:0];
                pg_s       = hold_r[15:8];
                pr_s       = d_s[7:0];
                hold_nx_s  = d_s[31:8];
                phase_nx_s = P3;
            end
            default: begin
                pb_s       = hold_r[7:0];
                pg_s       = hold_r[15:8];
                pr_s       = hold_r[23:16];
                hold_nx_s  = 24'h000000;
                phase_nx_s = P0;
            end
        endcase

        if (xe_s == X_LAST) begin
            xc_nx_s = 10'd0;
            yc_nx_s = y_adv_s;
        end else begin
            xc_nx_s = xe_s + 10'd1;
            yc_nx_s = ye_s;
        end

        // Early tlast: keep this word's pixel, drop held bytes, start a new line.
        if (eol_resync_s) begin
            phase_nx_s = P0;
            hold_nx_s  = 24'h000000;
            xc_nx_s    = 10'd0;
            yc_nx_s    = y_adv_s;
        end else begin
            phase_nx_s = phase_nx_s;
        end
    end

    // Phase, held bytes, coordinate counters and the output pixel register.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            run_r       <= 1'b0;
            phase_r     <= P0;
            hold_r      <= 24'h000000;
            xc_r        <= 10'd0;
            yc_r        <= 9'd0;
            r_r         <= 8'h00;
            g_r         <= 8'h00;
            b_r         <= 8'h00;
            x_r         <= 10'd0;
            y_r         <= 9'd0;
            sof_r       <= 1'b0;
            eol_r       <= 1'b0;
            pix_valid_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (step_s) begin
                phase_r     <= phase_nx_s;
                hold_r      <= hold_nx_s;
                xc_r        <= xc_nx_s;
                yc_r        <= yc_nx_s;
                r_r         <= pr_s;
                g_r         <= pg_s;
                b_r         <= pb_s;
                x_r         <= xe_s;
                y_r         <= ye_s;
                sof_r       <= (xe_s == 10'd0) && (ye_s == 9'd0);
                eol_r       <= (xe_s == X_LAST);
                pix_valid_r <= 1'b1;
            end else if (pix_ready) begin
                pix_valid_r <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps its flag set.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            sof_err_r <= 1'b0;
            eol_err_r <= 1'b0;
        end else begin
            if (sof_evt_s) begin
                sof_err_r <= 1'b1;
            end else if (err_clear) begin
                sof_err_r <= 1'b0;
            end
            if (eol_evt_s) begin
                eol_err_r <= 1'b1;
            end else if (err_clear) begin
                eol_err_r <= 1'b0;
            end
        end
    end

`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    logic [15:0] sof_cnt_r, eol_cnt_r;

    // Saturating error event counters; an event in the clearing cycle counts as one.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            sof_cnt_r <= 16'h0000;
            eol_cnt_r <= 16'h0000;
        end else begin
            if (err_clear) begin
                sof_cnt_r <= sof_evt_s ? 16'h0001 : 16'h0000;
            end else if (sof_evt_s && (sof_cnt_r != 16'hFFFF)) begin
                sof_cnt_r <= sof_cnt_r + 16'h0001;
            end
            if (err_clear) begin
                eol_cnt_r <= eol_evt_s ? 16'h0001 : 16'h0000;
            end else if (eol_evt_s && (eol_cnt_r != 16'hFFFF)) begin
                eol_cnt_r <= eol_cnt_r + 16'h0001;
            end
        end
    end

    assign sof_err_cnt = sof_cnt_r;
    assign eol_err_cnt = eol_cnt_r;
`endif

    assign in_stream.tready = in_ready_s;
    assign r         = r_r;
    assign g         = g_r;
    assign b         = b_r;
    assign x         = x_r;
    assign y         = y_r;
    assign sof       = sof_r;
    assign eol       = eol_r;
    assign pix_valid = pix_valid_r;
    assign sof_err   = sof_err_r;
    assign eol_err   = eol_err_r;

endmodule

// File: doc/pixel_unpacker.md
PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 SHALL have parameters: X_SIZE, default 640, pixels per line (multiple of 4); Y_SIZE, default 480, lines per frame.
REQ-002 SHALL have ports (clock and reset first): aclk in 1 sole clock; reset in 1 asynchronous active-high reset.
REQ-003 SHALL have ports: in_stream_tdata in 32 packed pixel bytes; in_stream_tkeep in 4 ignored; in_stream_tvalid in 1; in_stream_tready out 1; in_stream_tlast in 1 end of line; in_stream_tuser in 1 start of frame.
REQ-004 SHALL have ports: r, g, b out 8 each pixel colour; x out 10 column; y out 9 row; sof out 1 pixel is (0,0); eol out 1 pixel is x=X_SIZE-1; pix_valid out 1; pix_ready in 1.
REQ-005 SHALL have ports: sof_err out 1 sticky misplaced tuser; eol_err out 1 sticky misplaced or missing tlast; err_clear in 1 clears both sticky flags.

Function
REQ-006 SHALL treat the stream as a byte sequence, word byte i = tdata[8i+7:8i]; pixel n = bytes 3n (b), 3n+1 (g), 3n+2 (r); 4 pixels per 3 words; 3*X_SIZE/4 words per line.
REQ-007 SHALL use phase states P0, P1, P2, P3: P0 accepts word0, emits pixel0, holds 1 byte; P1 accepts word1, emits pixel1, holds 2 bytes; P2 accepts word2, emits pixel2, holds 3 bytes; P3 accepts no word, emits pixel3, returns to P0.
REQ-008 SHALL hold in_stream_tready low in P3 and whenever the output register holds an unconsumed pixel and pix_ready is low.
REQ-009 SHALL accept a word on tvalid&tready and present its pixel on r/g/b with pix_valid high exactly one cycle later (latency 1).
REQ-010 SHALL hold r, g, b, x, y, sof, eol and pix_valid stable while pix_valid&!pix_ready.
REQ-011 SHALL advance x on each pixel handshake; at x=X_SIZE-1, wrap x to 0 and advance y; at y=Y_SIZE-1, wrap y to 0.
REQ-012 SHALL sustain one pixel per cycle with pix_ready tied high: three words accepted in four cycles.
REQ-013 SHALL set sof_err when tuser is accepted on a word that is not the first word of the frame; it SHALL then resync: phase P0, x=0, y=0, and the word is decoded as word0 of the frame.
REQ-014 SHALL set eol_err when tlast is accepted on a word other than the last of a line; it SHALL then discard held bytes, set phase P0, set x=0, and advance y.
REQ-015 SHALL set eol_err when the last word of a line is accepted without tlast; it SHALL continue counting without resync.
REQ-016 SHALL give the set condition priority over err_clear in the same cycle.
REQ-017 SHALL drop no pixel and duplicate no pixel under any pattern of tvalid and pix_ready stalls.

Reset
REQ-018 SHALL, on reset assertion, clear immediately (asynchronously): phase P0, held bytes 0, x 0, y 0, r/g/b 0, pix_valid 0, sof 0, eol 0, in_stream_tready 0, sof_err 0, eol_err 0.
REQ-019 SHALL drive in_stream_tready high in the first cycle after reset release.
REQ-020 SHALL discard a partially received pixel group when reset is asserted mid-line, with no pixel emitted from it.

Configuration
REQ-021 SHALL, when PIXEL_UNPACKER_ERR_CNT_EN is defined, add outputs sof_err_cnt and eol_err_cnt, 16 bits each, incremented on each corresponding error event, saturating at 16'hFFFF, cleared by reset and err_clear.
REQ-022 SHALL, when PIXEL_UNPACKER_ERR_CNT_EN is undefined, omit both counter ports and logic and provide only the sticky flags.

Verification
REQ-023 SHALL cover: one full 640x480 frame of words with pix_ready=1, tuser and tlast placed correctly -> 307200 pixels; last pixel x=639, y=479; both error flags 0.
REQ-024 SHALL cover: words 0x33221100, 0x77665544, 0xBBAA9988 -> pixels (r,g,b) = (22,11,00), (55,44,33), (88,77,66), (BB,AA,99); tready low exactly in the P3 cycle.
REQ-025 SHALL cover: pix_ready held low 5 cycles after the first pixel -> outputs stable, tready low, no loss, and the next pixel appears the cycle after pix_ready rises.
REQ-026 SHALL cover: tuser asserted on word 30 of line 2 -> sof_err=1; the following pixel has x=0, y=0, sof=1.
REQ-027 SHALL cover: tlast asserted on word 100 of a line -> eol_err=1; the next pixel has x=0 and y incremented; with PIXEL_UNPACKER_ERR_CNT_EN, eol_err_cnt=1.
REQ-028 SHALL cover: reset pulsed after word1 of a group -> all outputs 0 asynchronously; after release, a new word0 decodes as pixel (0,0).
